// File: rtl/npu_inst_assembler.sv
// Collects PARTS host fragments into one instruction (fallback completion on inter-fragment timeout)
// and buffers completed instructions in a first-word-fall-through FIFO for the NPU decoder.
module npu_inst_assembler #(
  parameter int unsigned PART_W     = 32,
  parameter int unsigned PARTS      = 4,
  parameter int unsigned TIMEOUT    = 2000000,
  parameter int unsigned SHORT_MODE = 0,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                    npu_inst_clk,
  input  logic                    RESETN,
  input  logic [PART_W-1:0]       npu_inst_part,
  input  logic                    npu_inst_part_en,
  output logic [PARTS*PART_W-1:0] npu_inst,
  output logic                    npu_inst_short,
  output logic                    npu_inst_vld,
  input  logic                    npu_inst_rdy,
  input  logic                    err_clr,
  output logic                    err_short,
  output logic                    err_ovf,
  output logic [15:0]             drop_cnt,
  output logic [15:0]             inst_cnt
);

  localparam int unsigned INST_W = PART_W * PARTS;
  localparam int unsigned FW     = $clog2(PARTS);
  localparam int unsigned TW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned AW     = $clog2(FIFO_DEPTH);
  localparam logic [FW-1:0] LAST = FW'(PARTS - 1);
  localparam logic [TW-1:0] TMAX = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t            state, state_nx;
  logic [INST_W-1:0] sr, sr_nx, sr_shift;
  logic [FW-1:0]     frag_cnt, frag_nx;
  logic [TW-1:0]     timer, timer_nx;
  logic              push_req, push_short, tmo_fire;
  logic [INST_W-1:0] push_data;

  assign sr_shift = {sr[INST_W-PART_W-1:0], npu_inst_part};

  // sr is cleared on every completion so a later short instruction has zero-filled MSBs
  always_comb begin
    state_nx   = state;
    sr_nx      = sr;
    frag_nx    = frag_cnt;
    timer_nx   = timer;
    push_req   = 1'b0;
    push_short = 1'b0;
    push_data  = sr_shift;
    tmo_fire   = 1'b0;
    case (state)
      IDLE: begin
        if (npu_inst_part_en) begin
          sr_nx    = sr_shift;
          frag_nx  = FW'(1);
          timer_nx = '0;
          state_nx = COLLECT;
        end
      end
      COLLECT: begin
        if (npu_inst_part_en) begin
          timer_nx = '0;
          if (frag_cnt == LAST) begin
            push_req = 1'b1;
            sr_nx    = '0;
            frag_nx  = '0;
            state_nx = IDLE;
          end else begin
            sr_nx   = sr_shift;
            frag_nx = frag_cnt + FW'(1);
          end
        end else if ((TIMEOUT != 0) && (timer == TMAX)) begin
          tmo_fire   = 1'b1;
          push_req   = (SHORT_MODE != 0);
          push_short = 1'b1;
          push_data  = sr;
          sr_nx      = '0;
          frag_nx    = '0;
          timer_nx   = '0;
          state_nx   = IDLE;
        end else if (timer != '1) begin
          timer_nx = timer + TW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge npu_inst_clk) begin
    if (!RESETN) begin
      state     <= IDLE;
      sr        <= '0;
      frag_cnt  <= '0;
      timer     <= '0;
      err_short <= 1'b0;
    end else begin
      state     <= state_nx;
      sr        <= sr_nx;
      frag_cnt  <= frag_nx;
      timer     <= timer_nx;
      err_short <= tmo_fire;
    end
  end

  logic [INST_W:0] mem [FIFO_DEPTH];
  logic [AW-1:0]   wptr, rptr;
  logic [AW:0]     count;
  logic            full, pop, accept, drop;
  logic [INST_W:0] head;

  assign full         = (count == (AW+1)'(FIFO_DEPTH));
  assign npu_inst_vld = (count != '0);
  assign pop          = npu_inst_vld && npu_inst_rdy;
  assign accept       = push_req && (!full || pop);
  assign drop         = push_req && full && !pop;
  assign head         = mem[rptr];
  assign npu_inst       = npu_inst_vld ? head[INST_W-1:0] : '0;
  assign npu_inst_short = npu_inst_vld ? head[INST_W] : 1'b0;

  always_ff @(posedge npu_inst_clk) begin
    if (accept) mem[wptr] <= {push_short, push_data};
  end

  always_ff @(posedge npu_inst_clk) begin
    if (!RESETN) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      inst_cnt <= '0;
      drop_cnt <= '0;
      err_ovf  <= 1'b0;
    end else begin
      if (accept) wptr <= wptr + AW'(1);
      if (pop)    rptr <= rptr + AW'(1);
      if (accept && !pop)      count <= count + (AW+1)'(1);
      else if (!accept && pop) count <= count - (AW+1)'(1);
      if (accept) inst_cnt <= inst_cnt + 16'd1;
      // a drop in the clear cycle takes priority: the count restarts at one
      if (drop) begin
        err_ovf  <= 1'b1;
        drop_cnt <= err_clr ? 16'd1 : ((drop_cnt == '1) ? drop_cnt : drop_cnt + 16'd1);
      end else if (err_clr) begin
        err_ovf  <= 1'b0;
        drop_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_npu_inst_assembler.sv
// Scoreboard bench: stimulus queues expected instructions, a negedge monitor checks each handshake.
module tb_npu_inst_assembler;
  localparam int unsigned IW = 128;

  logic          clk = 1'b0;
  logic          resetn;
  logic [31:0]   part;
  logic          en, en0, rdy, err_clr, both;
  logic [IW-1:0] inst, inst0;
  logic          sh, sh0, vld, vld0, es, es0, ovf, ovf0;
  logic [15:0]   dcnt, dcnt0, icnt, icnt0;

  int errors = 0;
  int checks = 0;
  int pops = 0;
  int short_pulses = 0;
  logic [IW:0] sb [$];
  logic [IW:0] exp_e;

  always #5 clk = ~clk;

  npu_inst_assembler #(.PART_W(32), .PARTS(4), .TIMEOUT(16), .SHORT_MODE(1), .FIFO_DEPTH(4)) dut (
    .npu_inst_clk(clk), .RESETN(resetn), .npu_inst_part(part), .npu_inst_part_en(en),
    .npu_inst(inst), .npu_inst_short(sh), .npu_inst_vld(vld), .npu_inst_rdy(rdy),
    .err_clr(err_clr), .err_short(es), .err_ovf(ovf), .drop_cnt(dcnt), .inst_cnt(icnt));

  npu_inst_assembler #(.PART_W(32), .PARTS(4), .TIMEOUT(16), .SHORT_MODE(0), .FIFO_DEPTH(4)) dut0 (
    .npu_inst_clk(clk), .RESETN(resetn), .npu_inst_part(part), .npu_inst_part_en(en0),
    .npu_inst(inst0), .npu_inst_short(sh0), .npu_inst_vld(vld0), .npu_inst_rdy(1'b1),
    .err_clr(err_clr), .err_short(es0), .err_ovf(ovf0), .drop_cnt(dcnt0), .inst_cnt(icnt0));

  always @(negedge clk) begin
    if (es) short_pulses++;
    if (resetn && vld && rdy) begin
      checks++;
      pops++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL pop: unexpected instruction %h short=%b, none expected", inst, sh);
      end else begin
        exp_e = sb.pop_front();
        if ({sh, inst} !== exp_e) begin
          errors++;
          $display("FAIL pop: got short=%b inst=%h, expected short=%b inst=%h",
                   sh, inst, exp_e[IW], exp_e[IW-1:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic send_part(input logic [31:0] p);
    @(posedge clk); #1;
    part = p;
    en   = 1'b1;
    en0  = both;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      en  = 1'b0;
      en0 = 1'b0;
    end
  endtask

  // returns just after the edge that samples the last fragment
  task automatic send_inst(input logic [127:0] v, input bit keep, input bit clr_last, input bit rdy_last);
    for (int i = 0; i < 3; i++) send_part(v[127-32*i -: 32]);
    send_part(v[31:0]);
    err_clr = clr_last;
    if (rdy_last) rdy = 1'b1;
    @(posedge clk); #1;
    en      = 1'b0;
    err_clr = 1'b0;
    if (rdy_last) rdy = 1'b0;
    if (keep) sb.push_back({1'b0, v});
  endtask

  function automatic logic [127:0] mk(input logic [7:0] b);
    return {b, 24'h000001, b, 24'h000002, b, 24'h000003, b, 24'h000004};
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, base_p, base_s;
    bit found;
    logic f0;
    resetn = 1'b0; part = '0; en = 1'b0; en0 = 1'b0; rdy = 1'b0; err_clr = 1'b0; both = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_vld", 128'(vld), 128'(0));
    check("rst_inst", inst, 128'(0));
    check("rst_cnt", 128'({icnt, dcnt}), 128'(0));
    check("rst_err", 128'({ovf, es, sh}), 128'(0));
    resetn = 1'b1;

    // back-to-back full instruction, one-cycle latency
    send_inst(128'h11111111_22222222_33333333_44444444, 1'b1, 1'b0, 1'b0);
    check("lat_vld", 128'(vld), 128'(1));
    check("lat_icnt", 128'(icnt), 128'(1));
    rdy = 1'b1;
    idle(2);
    check("drain1_vld", 128'(vld), 128'(0));

    // timeout completion: short emit on dut, drop on dut0
    both = 1'b1;
    send_part(32'hAAAA0001);
    send_part(32'hAAAA0002);
    both = 1'b0;
    sb.push_back({1'b1, 128'h00000000_00000000_AAAA0001_AAAA0002});
    n = 999; found = 1'b0; f0 = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk); #1;
      en = 1'b0; en0 = 1'b0;
      if (es) begin found = 1'b1; n = i; f0 = es0; end
    end
    check("tmo_cycles", 128'(n), 128'(16));
    check("tmo_es0", 128'(f0), 128'(1));
    idle(1);
    check("tmo_pulse_width", 128'(es), 128'(0));
    idle(2);
    check("tmo_drop_vld0", 128'(vld0), 128'(0));
    check("tmo_drop_icnt0", 128'(icnt0), 128'(0));
    check("tmo_icnt", 128'(icnt), 128'(2));

    // overflow: 4 held, 5th dropped
    rdy = 1'b0;
    for (int k = 0; k < 5; k++) send_inst(mk(8'h30 + 8'(k)), k < 4, 1'b0, 1'b0);
    idle(1);
    check("ovf_flag", 128'(ovf), 128'(1));
    check("ovf_drop", 128'(dcnt), 128'(1));
    check("ovf_icnt", 128'(icnt), 128'(6));
    send_inst(mk(8'h40), 1'b0, 1'b1, 1'b0);
    check("clr_vs_drop_flag", 128'(ovf), 128'(1));
    check("clr_vs_drop_cnt", 128'(dcnt), 128'(1));
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    check("clr_flag", 128'(ovf), 128'(0));
    check("clr_cnt", 128'(dcnt), 128'(0));

    // full FIFO, pop in the cycle of the last fragment: accepted
    send_inst(mk(8'h50), 1'b1, 1'b0, 1'b1);
    check("fullpop_drop", 128'({ovf, dcnt}), 128'(0));
    check("fullpop_icnt", 128'(icnt), 128'(7));
    base_p = pops;
    rdy = 1'b1;
    idle(8);
    check("fullpop_occupancy", 128'(pops - base_p), 128'(4));
    check("fullpop_sb_empty", 128'(sb.size()), 128'(0));

    // fragment exactly on the timeout cycle wins
    base_s = short_pulses;
    send_part(32'h55550001);
    idle(15);
    send_part(32'h55550002);
    send_part(32'h55550003);
    send_part(32'h55550004);
    sb.push_back({1'b0, 128'h55550001_55550002_55550003_55550004});
    idle(25);
    check("edge_no_tmo", 128'(short_pulses - base_s), 128'(0));
    check("edge_icnt", 128'(icnt), 128'(8));

    // reset mid-instruction
    send_part(32'h66660001);
    send_part(32'h66660002);
    @(posedge clk); #1;
    en = 1'b0;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    check("midrst_icnt", 128'(icnt), 128'(0));
    base_s = short_pulses;
    base_p = pops;
    send_inst(128'h77770001_77770002_77770003_77770004, 1'b1, 1'b0, 1'b0);
    idle(25);
    check("midrst_pops", 128'(pops - base_p), 128'(1));
    check("midrst_no_short", 128'(short_pulses - base_s), 128'(0));
    check("midrst_icnt_after", 128'(icnt), 128'(1));
    check("final_sb_empty", 128'(sb.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
